// File: rtl/mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_sequencer_if
// Purpose : bundles the fetch requester, load/store requester and memory pins
//           seen by mem_sequencer.
// Signals : if_req/if_pc -> if_valid/if_instr       (instruction fetch)
//           ls_req/ls_we/ls_addr/ls_wdata -> ls_valid/ls_rdata (load/store)
//           mem_read/mem_write/mem_address/mem_wdata <- mem_rdata (memory)
//           busy                                       (sequencer not idle)
// Modports: slave  - the sequencer side
//           master - the requester/memory side
// -----------------------------------------------------------------------------
interface mem_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_pc;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_valid;
   logic [DATA_W-1:0] ls_rdata;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_pc, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_valid, if_instr, ls_valid, ls_rdata,
      output mem_read, mem_write, mem_address, mem_wdata, busy
   );

   modport master (
      output if_req, if_pc, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_valid, if_instr, ls_valid, ls_rdata,
      input  mem_read, mem_write, mem_address, mem_wdata, busy
   );
endinterface

// File: rtl/mem_sequencer.sv
// -----------------------------------------------------------------------------
// mem_sequencer
// Purpose : arbitrates fetch and load/store requests onto a single memory with
//           a one-cycle registered read, one access in flight at a time.
//           Fetch/load: accept -> ISSUE (mem_read) -> CAPTURE -> valid pulse.
//           Store     : accept -> ISSUE (mem_write) -> ls_valid pulse.
// Ports   : i_clk   - system clock, rising edge
//           i_reset - synchronous active-high reset
//           io_bus  - mem_sequencer_if.slave (requesters, memory pins, busy)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic           i_clk,
   input  logic           i_reset,
   mem_sequencer_if.slave io_bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

   state_e              r_state,       w_state_d;
   logic                r_last_ls,     w_last_ls_d;   // last contention winner: 1 = load/store
   logic                r_src_ls,      w_src_ls_d;    // source of the access in flight
   logic                r_we,          w_we_d;
   logic                r_mem_read,    w_mem_read_d;
   logic                r_mem_write,   w_mem_write_d;
   logic [ADDR_W-1:0]   r_mem_address, w_mem_address_d;
   logic [DATA_W-1:0]   r_mem_wdata,   w_mem_wdata_d;
   logic                r_if_valid,    w_if_valid_d;
   logic [DATA_W-1:0]   r_if_instr,    w_if_instr_d;
   logic                r_ls_valid,    w_ls_valid_d;
   logic [DATA_W-1:0]   r_ls_rdata,    w_ls_rdata_d;
   logic                r_busy,        w_busy_d;
   logic                w_grant_ls;

   // Under contention the side that lost the previous contention wins; the
   // winner is only remembered when both requests were actually competing.
   assign w_grant_ls = io_bus.ls_req && (!io_bus.if_req || !r_last_ls);

   always_comb begin
      w_state_d       = r_state;
      w_last_ls_d     = r_last_ls;
      w_src_ls_d      = r_src_ls;
      w_we_d          = r_we;
      w_mem_read_d    = 1'b0;
      w_mem_write_d   = 1'b0;
      w_mem_address_d = r_mem_address;
      w_mem_wdata_d   = r_mem_wdata;
      w_if_valid_d    = 1'b0;
      w_if_instr_d    = r_if_instr;
      w_ls_valid_d    = 1'b0;
      w_ls_rdata_d    = r_ls_rdata;
      w_busy_d        = r_busy;

      unique case (r_state)
         StIdle: begin
            if (io_bus.if_req || io_bus.ls_req) begin
               if (io_bus.if_req && io_bus.ls_req) begin
                  w_last_ls_d = w_grant_ls;
               end
               w_src_ls_d      = w_grant_ls;
               w_we_d          = w_grant_ls && io_bus.ls_we;
               w_mem_address_d = w_grant_ls ? io_bus.ls_addr : io_bus.if_pc;
               if (w_grant_ls) begin
                  w_mem_wdata_d = io_bus.ls_wdata;
               end
               w_mem_read_d    = !w_we_d;
               w_mem_write_d   = w_we_d;
               w_busy_d        = 1'b1;
               w_state_d       = StIssue;
            end
         end
         StIssue: begin
            if (r_we) begin
               // Store is committed by the memory at this edge.
               w_ls_valid_d = 1'b1;
               w_busy_d     = 1'b0;
               w_state_d    = StIdle;
            end else begin
               w_state_d    = StCapture;
            end
         end
         StCapture: begin
            if (r_src_ls) begin
               w_ls_rdata_d = io_bus.mem_rdata;
               w_ls_valid_d = 1'b1;
            end else begin
               w_if_instr_d = io_bus.mem_rdata;
               w_if_valid_d = 1'b1;
            end
            w_busy_d  = 1'b0;
            w_state_d = StIdle;
         end
         default: begin
            w_busy_d  = 1'b0;
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_last_ls     <= 1'b0;
         r_src_ls      <= 1'b0;
         r_we          <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_address <= '0;
         r_mem_wdata   <= '0;
         r_if_valid    <= 1'b0;
         r_if_instr    <= '0;
         r_ls_valid    <= 1'b0;
         r_ls_rdata    <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_last_ls     <= w_last_ls_d;
         r_src_ls      <= w_src_ls_d;
         r_we          <= w_we_d;
         r_mem_read    <= w_mem_read_d;
         r_mem_write   <= w_mem_write_d;
         r_mem_address <= w_mem_address_d;
         r_mem_wdata   <= w_mem_wdata_d;
         r_if_valid    <= w_if_valid_d;
         r_if_instr    <= w_if_instr_d;
         r_ls_valid    <= w_ls_valid_d;
         r_ls_rdata    <= w_ls_rdata_d;
         r_busy        <= w_busy_d;
      end
   end

   assign io_bus.mem_read    = r_mem_read;
   assign io_bus.mem_write   = r_mem_write;
   assign io_bus.mem_address = r_mem_address;
   assign io_bus.mem_wdata   = r_mem_wdata;
   assign io_bus.if_valid    = r_if_valid;
   assign io_bus.if_instr    = r_if_instr;
   assign io_bus.ls_valid    = r_ls_valid;
   assign io_bus.ls_rdata    = r_ls_rdata;
   assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_sequencer
// Drives mem_sequencer through directed and random fetch/load/store traffic.
// The memory is modelled inside the single stimulus process (registered read,
// write on the edge), and expected data comes from a shadow copy of memory
// updated in request-grant order.
// -----------------------------------------------------------------------------
module tb_mem_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   mem_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .io_bus (bus)
   );

   logic [15:0] mem     [256];
   logic [15:0] ref_mem [256];
   logic [15:0] ref_last_if;
   logic [15:0] ref_last_ld;
   bit          ref_ls_next;    // who wins the next contention

   int n_cmp = 0;
   int n_err = 0;

   int          n_rd, n_wr, n_both, n_busy;
   logic [7:0]  mon_addr;
   logic [15:0] mon_wdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      n_rd = 0; n_wr = 0; n_both = 0; n_busy = 0;
      mon_addr = '0; mon_wdata = '0;
   endtask

   // One clock: memory acts on the pins as they were before the edge, then the
   // post-edge outputs are tallied.
   task automatic step();
      logic        pr, pw;
      logic [7:0]  pa;
      logic [15:0] pd;
      pr = bus.mem_read; pw = bus.mem_write; pa = bus.mem_address; pd = bus.mem_wdata;
      @(posedge clk);
      #1;
      if (pw === 1'b1) mem[pa] = pd;
      if (pr === 1'b1) bus.mem_rdata = mem[pa];
      if (bus.mem_read === 1'b1) n_rd++;
      if (bus.mem_write === 1'b1) n_wr++;
      if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) n_both++;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
         mon_addr  = bus.mem_address;
         mon_wdata = bus.mem_wdata;
      end
      if (bus.busy === 1'b1) n_busy++;
   endtask

   task automatic single(input bit is_ls, input bit we, input logic [7:0] a,
                         input logic [15:0] wd);
      int          lat;
      bit          got;
      bit          st;
      logic [15:0] data;
      st = is_ls && we;
      clr_mon();
      if (is_ls) begin
         bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = a; bus.ls_wdata = wd;
      end else begin
         bus.if_req = 1'b1; bus.if_pc = a;
      end
      lat = 0; got = 1'b0;
      while (!got && lat < 12) begin
         step();
         lat++;
         if (lat == 1) begin
            // Requester pins wander after acceptance; the access must not care.
            bus.if_pc    = 8'($urandom);
            bus.ls_addr  = 8'($urandom);
            bus.ls_wdata = 16'($urandom);
            bus.ls_we    = 1'($urandom);
         end
         got = is_ls ? (bus.ls_valid === 1'b1) : (bus.if_valid === 1'b1);
      end
      data = is_ls ? bus.ls_rdata : bus.if_instr;
      bus.if_req = 1'b0; bus.ls_req = 1'b0;
      check("valid_seen", 64'(got), 64'(1));
      check("latency", 64'(lat), st ? 64'(2) : 64'(3));
      check("busy_cycles", 64'(n_busy), st ? 64'(1) : 64'(2));
      check("rd_strobes", 64'(n_rd), st ? 64'(0) : 64'(1));
      check("wr_strobes", 64'(n_wr), st ? 64'(1) : 64'(0));
      check("both_strobes", 64'(n_both), 64'(0));
      check("mem_address", 64'(mon_addr), 64'(a));
      if (st) begin
         check("mem_wdata", 64'(mon_wdata), 64'(wd));
         check("ls_rdata_hold", 64'(bus.ls_rdata), 64'(ref_last_ld));
         ref_mem[a] = wd;
      end else if (is_ls) begin
         check("ls_rdata", 64'(data), 64'(ref_mem[a]));
         check("if_instr_hold", 64'(bus.if_instr), 64'(ref_last_if));
         ref_last_ld = ref_mem[a];
      end else begin
         check("if_instr", 64'(data), 64'(ref_mem[a]));
         check("ls_rdata_hold", 64'(bus.ls_rdata), 64'(ref_last_ld));
         ref_last_if = ref_mem[a];
      end
      step();
      check("valid_drop", 64'({bus.if_valid, bus.ls_valid}), 64'(0));
   endtask

   task automatic contend(input logic [7:0] pc, input bit we, input logic [7:0] a,
                          input logic [15:0] wd);
      bit          ls_first;
      int          cyc, if_cyc, ls_cyc, lat_ls;
      logic [15:0] if_data, ls_data, exp_if, exp_ls;
      ls_first    = ref_ls_next;
      ref_ls_next = !ref_ls_next;
      lat_ls      = we ? 2 : 3;
      if (ls_first) begin
         exp_ls = ref_mem[a];
         if (we) ref_mem[a] = wd;
         exp_if = ref_mem[pc];
      end else begin
         exp_if = ref_mem[pc];
         exp_ls = ref_mem[a];
         if (we) ref_mem[a] = wd;
      end
      clr_mon();
      bus.if_req = 1'b1; bus.if_pc = pc;
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = a; bus.ls_wdata = wd;
      cyc = 0; if_cyc = 0; ls_cyc = 0; if_data = '0; ls_data = '0;
      while ((if_cyc == 0 || ls_cyc == 0) && cyc < 20) begin
         step();
         cyc++;
         if (bus.if_valid === 1'b1) begin
            if_cyc = cyc; if_data = bus.if_instr; bus.if_req = 1'b0;
         end
         if (bus.ls_valid === 1'b1) begin
            ls_cyc = cyc; ls_data = bus.ls_rdata; bus.ls_req = 1'b0;
         end
      end
      bus.if_req = 1'b0; bus.ls_req = 1'b0;
      check("arb_if_cycle", 64'(if_cyc), ls_first ? 64'(lat_ls + 3) : 64'(3));
      check("arb_ls_cycle", 64'(ls_cyc), ls_first ? 64'(lat_ls) : 64'(3 + lat_ls));
      check("arb_if_instr", 64'(if_data), 64'(exp_if));
      if (we) begin
         check("arb_ls_rdata_hold", 64'(ls_data), 64'(ref_last_ld));
      end else begin
         check("arb_ls_rdata", 64'(ls_data), 64'(exp_ls));
         ref_last_ld = exp_ls;
      end
      ref_last_if = exp_if;
      check("arb_rd_strobes", 64'(n_rd), we ? 64'(1) : 64'(2));
      check("arb_wr_strobes", 64'(n_wr), we ? 64'(1) : 64'(0));
      check("arb_both_strobes", 64'(n_both), 64'(0));
      step();
      check("arb_valid_drop", 64'({bus.if_valid, bus.ls_valid}), 64'(0));
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.if_valid, bus.if_instr, bus.ls_valid, bus.ls_rdata, bus.mem_read,
                  bus.mem_write, bus.mem_address, bus.mem_wdata, bus.busy});
   endfunction

   initial begin
      int          cyc, prev;
      bit          got;
      logic [7:0]  sa;
      logic [15:0] sd;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[1]  = 16'h9210; ref_mem[1]  = 16'h9210;
      mem[2]  = 16'h931E; ref_mem[2]  = 16'h931E;
      mem[3]  = 16'h1423; ref_mem[3]  = 16'h1423;
      mem[4]  = 16'hA40C; ref_mem[4]  = 16'hA40C;
      mem[5]  = 16'h911E; ref_mem[5]  = 16'h911E;
      mem[30] = 16'h0004; ref_mem[30] = 16'h0004;
      ref_last_if = '0; ref_last_ld = '0; ref_ls_next = 1'b1;

      bus.if_req = 1'b0; bus.if_pc = '0;
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
      bus.mem_rdata = '0;
      clr_mon();

      // Reset then idle
      reset = 1'b1;
      step(); check("reset_outs_c1", all_outs(), 64'(0));
      step(); check("reset_outs_c2", all_outs(), 64'(0));
      reset = 1'b0;
      step(); check("idle_outs", all_outs(), 64'(0));

      // Single fetch, then store and load back
      single(1'b0, 1'b0, 8'd5, 16'h0000);
      single(1'b1, 1'b1, 8'd16, 16'h0010);
      single(1'b1, 1'b0, 8'd16, 16'h0000);

      // Contention: first goes to load/store, the next to fetch
      contend(8'd1, 1'b0, 8'd30, 16'h0000);
      contend(8'd2, 1'b0, 8'd16, 16'h0000);

      // Back-to-back fetches with if_req held high
      bus.if_req = 1'b1; bus.if_pc = 8'd1;
      prev = 0; cyc = 0;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         while (!got && cyc < prev + 10) begin
            step();
            cyc++;
            got = (bus.if_valid === 1'b1);
         end
         check("b2b_instr", 64'(bus.if_instr), 64'(ref_mem[k + 1]));
         check("b2b_spacing", 64'(cyc - prev), 64'(3));
         prev = cyc;
         if (k == 3) bus.if_req = 1'b0;
         else bus.if_pc = 8'(k + 2);
      end
      ref_last_if = ref_mem[4];
      step();
      check("b2b_drop", 64'(bus.if_valid), 64'(0));

      // Reset during a load's CAPTURE cycle
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 8'd30;
      step();
      step();
      check("cap_busy", 64'({bus.busy, bus.ls_valid}), 64'(2'b10));
      reset = 1'b1; bus.ls_req = 1'b0;
      step();
      check("cap_rst_outs", all_outs(), 64'(0));
      reset = 1'b0;
      step();
      check("cap_rst_after", 64'({bus.ls_valid, bus.busy}), 64'(0));
      ref_last_if = '0; ref_last_ld = '0; ref_ls_next = 1'b1;

      // Reset during a store's ISSUE cycle: memory still takes the write
      sa = 8'h40; sd = 16'($urandom);
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = sa; bus.ls_wdata = sd;
      step();
      check("st_issue_pins", 64'({bus.mem_write, bus.mem_address, bus.mem_wdata}),
            64'({1'b1, sa, sd}));
      reset = 1'b1; bus.ls_req = 1'b0;
      step();
      check("st_rst_valid", 64'({bus.ls_valid, bus.busy, bus.mem_write}), 64'(0));
      reset = 1'b0;
      step();
      check("st_rst_valid2", 64'(bus.ls_valid), 64'(0));
      step();
      check("st_rst_valid3", 64'(bus.ls_valid), 64'(0));
      check("st_rst_mem", 64'(mem[sa]), 64'(sd));
      ref_mem[sa] = sd;
      single(1'b1, 1'b0, sa, 16'h0000);

      // Random traffic
      for (int n = 0; n < 40; n++) begin
         int op;
         op = int'($urandom_range(0, 3));
         case (op)
            0: single(1'b0, 1'b0, 8'($urandom), 16'h0000);
            1: single(1'b1, 1'b0, 8'($urandom), 16'h0000);
            2: single(1'b1, 1'b1, 8'($urandom), 16'($urandom));
            default: contend(8'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
         endcase
         repeat ($urandom_range(0, 2)) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
